branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 5, giving log2 of the table depth (32 entries).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port if_pc, input, 32, the fetch-stage PC to predict.
REQ-005 SHALL have port pred_taken, output, 1, the fetch-stage taken prediction.
REQ-006 SHALL have port pred_target, output, 32, the predicted next PC.
REQ-007 SHALL have port ex_valid, input, 1, an execute-stage instruction is present.
REQ-008 SHALL have port ex_stall, input, 1, the execute stage is held; blocks updates.
REQ-009 SHALL have port ex_is_branch, input, 1, the execute instruction is a conditional branch.
REQ-010 SHALL have port ex_pc, input, 32, the execute-stage branch PC.
REQ-011 SHALL have port ex_br_en, input, 1, the resolved outcome from the branch comparator.
REQ-012 SHALL have port ex_target, input, 32, the computed branch target.
REQ-013 SHALL have ports ex_pred_taken (input, 1) and ex_pred_target (input, 32), the prediction carried down the pipe.
REQ-014 SHALL have ports mispredict (output, 1) and redirect_pc (output, 32), the flush request and the correct next PC.
REQ-015 SHALL have ports br_count and mp_count, output, 32 each, the resolved-branch and misprediction counters.

Function
REQ-016 SHALL compute index = pc[IDX_BITS+1:2] and tag = pc[31:IDX_BITS+2].
  - Each entry holds a 2-bit counter, a valid bit, a tag and a 32-bit target.
REQ-017 SHALL assert pred_taken combinationally only when all of the following hold:
  - the entry at index(if_pc) is valid;
  - the stored tag equals tag(if_pc);
  - counter[1] = 1.
REQ-018 SHALL drive pred_target = stored target when pred_taken = 1, else if_pc + 4 (modulo 2^32).
REQ-019 SHALL define an update event as ex_valid & ex_is_branch & ~ex_stall & ~rst.
  - No table or counter state changes without an update event.
REQ-020 SHALL, on an update event, saturate the counter: increment if ex_br_en = 1, decrement if 0.
  - Clamp at 2'b11 and 2'b00.
REQ-021 SHALL, on an update event with ex_br_en = 1, write valid = 1, tag(ex_pc) and ex_target into the entry.
  - On a tag miss, also load the counter with 2'b10 instead of incrementing.
REQ-022 SHALL, on an update event with ex_br_en = 0 and a tag miss, leave the entry unchanged.
REQ-023 SHALL drive mispredict combinationally on an update event when either holds:
  - ex_br_en != ex_pred_taken;
  - ex_br_en = 1, ex_pred_taken = 1 and ex_target != ex_pred_target.
  - mispredict is 0 otherwise.
REQ-024 SHALL drive redirect_pc = ex_target when ex_br_en = 1, else ex_pc + 4; the value is meaningful only while mispredict = 1.
REQ-025 SHALL have no read bypass: a lookup and an update to the same index in the same cycle returns the pre-update entry.
  - The new value is visible from the next cycle.
REQ-026 SHALL increment br_count by 1 per update event, and mp_count by 1 per update event with mispredict = 1.
  - Both wrap from 0xFFFFFFFF to 0.
REQ-027 SHALL hold all state while ex_stall = 1, even if ex_valid = 1 and ex_is_branch = 1.
  - mispredict SHALL read 0 during the stall.

Reset
REQ-028 SHALL, on rst = 1 at a clock edge, perform all of the following:
  - clear every valid bit;
  - set every counter to 2'b01 (weakly not-taken);
  - zero br_count and mp_count.
REQ-029 SHALL, while rst = 1, output pred_taken = 0, pred_target = if_pc + 4 and mispredict = 0.
  - An update arriving in the same cycle as rst SHALL be discarded.

Structure
REQ-030 SHALL place the following in the shared rv32i types package, alongside branch_funct3_t:
  - typedef pred_ctr_t, an enum: SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11;
  - the PC increment constant (4).
REQ-031 SHALL instantiate one sub-module, sat_ctr2, holding the per-entry saturating-counter next-state logic.
  - Tables are plain register arrays in branch_predictor.

Verification
REQ-032 SHALL check reset: apply rst, then if_pc = 0x100 -> pred_taken = 0, pred_target = 0x104, br_count = mp_count = 0.
REQ-033 SHALL check first-taken allocation:
  - Stimulus: one update with ex_pc = 0x100, ex_br_en = 1, ex_target = 0x80, ex_pred_taken = 0.
  - Same cycle: mispredict = 1, redirect_pc = 0x80.
  - Next cycle with if_pc = 0x100: pred_taken = 1, pred_target = 0x80.
REQ-034 SHALL check saturation: four not-taken updates at 0x100 after REQ-033 -> counter reaches 2'b00 and stays there; pred_taken = 0 after the first.
REQ-035 SHALL check aliasing: ex_pc = 0x180 (same index, different tag, IDX_BITS = 5) taken to 0x40 -> if_pc = 0x100 then misses, pred_target = 0x104.
REQ-036 SHALL check stall and wrong target:
  - Update with ex_stall = 1 -> no state or counter change.
  - Then ex_pred_taken = 1, ex_pred_target = 0x80, ex_target = 0x90, ex_br_en = 1 -> mispredict = 1, redirect_pc = 0x90, mp_count += 1.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types: branch funct3 encodings, 2-bit predictor counter states
// and the sequential PC increment.
package rv32i_types_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_funct3_t;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pred_ctr_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// Next-state logic for one 2-bit saturating direction counter. A taken branch
// that misses on tag allocates the entry as weakly-taken.
module sat_ctr2
  import rv32i_types_pkg::*;
(
  input  pred_ctr_t ctr_i,
  input  logic      hit_i,
  input  logic      taken_i,
  output pred_ctr_t ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i && !hit_i) begin
      ctr_o = WT;
    end else if (hit_i) begin
      if (taken_i) begin
        case (ctr_i)
          SNT:     ctr_o = WNT;
          WNT:     ctr_o = WT;
          default: ctr_o = ST;
        endcase
      end else begin
        case (ctr_i)
          ST:      ctr_o = WT;
          WT:      ctr_o = WNT;
          default: ctr_o = SNT;
        endcase
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged BTB with 2-bit direction counters: fetch-stage lookup,
// execute-stage update, misprediction detection and branch statistics.
module branch_predictor
  import rv32i_types_pkg::*;
#(
  parameter int IDX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_br_en,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam int TAG_W = 30 - IDX_BITS;

  logic [DEPTH-1:0] valid_q, valid_d;
  pred_ctr_t        ctr_q [DEPTH];
  pred_ctr_t        ctr_d [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];
  logic [31:0]      tgt_q [DEPTH];
  logic [31:0]      tgt_d [DEPTH];
  logic [31:0]      br_count_q, br_count_d;
  logic [31:0]      mp_count_q, mp_count_d;

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]    if_tag, ex_tag;
  logic                if_hit, ex_hit, upd;
  pred_ctr_t           ctr_upd;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[31:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[31:IDX_BITS+2];

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = !rst && if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + PC_INC;

  assign upd    = ex_valid && ex_is_branch && !ex_stall && !rst;
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign mispredict  = upd && ((ex_br_en != ex_pred_taken) ||
                               (ex_br_en && ex_pred_taken && (ex_target != ex_pred_target)));
  assign redirect_pc = ex_br_en ? ex_target : ex_pc + PC_INC;

  sat_ctr2 u_sat_ctr2 (
    .ctr_i   (ctr_q[ex_idx]),
    .hit_i   (ex_hit),
    .taken_i (ex_br_en),
    .ctr_o   (ctr_upd)
  );

  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (upd) begin
      ctr_d[ex_idx] = ctr_upd;
      if (ex_br_en) begin
        valid_d[ex_idx] = 1'b1;
        tag_d[ex_idx]   = ex_tag;
        tgt_d[ex_idx]   = ex_target;
      end
    end
  end

  assign br_count_d = br_count_q + {31'd0, upd};
  assign mp_count_d = mp_count_q + {31'd0, mispredict};

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      br_count_q <= '0;
      mp_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= WNT;
    end else begin
      valid_q    <= valid_d;
      ctr_q      <= ctr_d;
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

  // Tags and targets are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;

endmodule
